// File: rtl/fifo_axi_burst_writer.sv
// -----------------------------------------------------------------------------
// fifo_axi_burst_writer
//
// Read-clock-domain consumer of an async FIFO. Pops bytes, packs them
// little-endian into 32-bit words, buffers one burst and issues it as an
// AXI4 INCR write burst. Bursts walk a circular region starting at BASE_ADDR
// in BURST_LEN*4-byte steps. A flush pulse forces out a partial burst.
//
// Ports:
//   rclk, rrst          clock and asynchronous active-low reset
//   fifo_empty/data     FIFO read side (data valid the cycle after fifo_r_en)
//   fifo_r_en           FIFO read enable
//   flush               single-cycle request to write out a partial burst
//   aw*/w*/b*           AXI4 write address, data and response channels
//   busy                high unless idle in FILL with nothing buffered
//   err                 sticky, set on any non-OKAY write response
//   bytes_written       running count of strobed bytes in completed bursts
// -----------------------------------------------------------------------------
module fifo_axi_burst_writer #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    AXI_DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    BURST_LEN      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    REGION_BYTES   = 4096
) (
    input  logic                        rclk,
    input  logic                        rrst,
    input  logic                        fifo_empty,
    input  logic [DATA_WIDTH-1:0]       fifo_data,
    output logic                        fifo_r_en,
    input  logic                        flush,
    output logic [ADDR_WIDTH-1:0]       awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [AXI_DATA_WIDTH-1:0]   wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,
    output logic                        busy,
    output logic                        err,
    output logic [31:0]                 bytes_written
);

    localparam int BYTES = BURST_LEN * 4;
    localparam int CW    = $clog2(BYTES + 1);
    localparam int BW    = $clog2(BURST_LEN * 32);

    localparam logic [CW:0]           FULL   = (CW + 1)'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] REGION = ADDR_WIDTH'(REGION_BYTES);

    typedef enum logic [1:0] {FILL, AW, W, B} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic                      inflight;
    logic                      flush_pend;
    logic [ADDR_WIDTH-1:0]     offset;
    logic [BURST_LEN*32-1:0]   buf_q;
    logic [7:0]                beat;

    logic [7:0]                nxt_beat;
    logic [BW-1:0]             rd_bit;
    logic [BW-1:0]             wr_bit;
    logic [31:0]               rd_word;
    logic [3:0]                last_strb;
    logic [3:0]                nxt_strb;
    logic [ADDR_WIDTH-1:0]     off_sum;
    logic [ADDR_WIDTH-1:0]     nxt_off;

    assign awsize  = 3'b010;
    assign awburst = 2'b01;

    always_comb begin
        fifo_r_en = rrst && (state == FILL) && !fifo_empty && !flush_pend &&
                    (({1'b0, cnt} + {{CW{1'b0}}, inflight}) < FULL);
        busy      = (state != FILL) || (cnt != '0);
        // Beat to be presented next: 0 when leaving AW, beat+1 inside W.
        nxt_beat  = (state == AW) ? 8'd0 : beat + 8'd1;
        rd_bit    = BW'({nxt_beat, 5'b00000});
        rd_word   = buf_q[rd_bit +: 32];
        wr_bit    = BW'({cnt, 3'b000});
        last_strb = (cnt[1:0] == 2'b00) ? 4'hF : ((4'd1 << cnt[1:0]) - 4'd1);
        nxt_strb  = (nxt_beat == awlen) ? last_strb : 4'hF;
        off_sum   = offset + STEP;
        nxt_off   = (off_sum >= REGION) ? '0 : off_sum;
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            state         <= FILL;
            cnt           <= '0;
            inflight      <= 1'b0;
            flush_pend    <= 1'b0;
            offset        <= '0;
            buf_q         <= '0;
            beat          <= '0;
            awaddr        <= BASE_ADDR;
            awlen         <= '0;
            awvalid       <= 1'b0;
            wdata         <= '0;
            wstrb         <= '0;
            wlast         <= 1'b0;
            wvalid        <= 1'b0;
            bready        <= 1'b0;
            err           <= 1'b0;
            bytes_written <= '0;
        end else begin
            if (flush) flush_pend <= 1'b1;
            case (state)
                FILL: begin
                    if (inflight) begin
                        buf_q[wr_bit +: 8] <= fifo_data;
                        cnt                <= cnt + CW'(1);
                    end
                    inflight <= fifo_r_en;
                    if (!inflight) begin
                        if (cnt == CW'(BYTES) || (flush_pend && cnt != '0)) begin
                            // The pending flush is consumed at launch, so a
                            // flush arriving during AW/W/B survives into the
                            // next FILL.
                            flush_pend <= flush;
                            state      <= AW;
                            awvalid    <= 1'b1;
                            awaddr     <= BASE_ADDR + offset;
                            awlen      <= 8'((cnt - CW'(1)) >> 2);
                        end else if (flush_pend) begin
                            flush_pend <= flush;
                        end
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= W;
                        beat    <= '0;
                        wvalid  <= 1'b1;
                        wdata   <= rd_word;
                        wstrb   <= nxt_strb;
                        wlast   <= (awlen == 8'd0);
                    end
                end
                W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= B;
                        end else begin
                            beat  <= nxt_beat;
                            wdata <= rd_word;
                            wstrb <= nxt_strb;
                            wlast <= (nxt_beat == awlen);
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready        <= 1'b0;
                        if (bresp != 2'b00) err <= 1'b1;
                        bytes_written <= bytes_written + 32'(cnt);
                        offset        <= nxt_off;
                        cnt           <= '0;
                        state         <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_axi_burst_writer.sv
module tb_fifo_axi_burst_writer;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        fifo_empty;
    logic [7:0]  fifo_data = '0;
    logic        fifo_r_en;
    logic        flush;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        busy;
    logic        err;
    logic [31:0] bytes_written;

    int checks = 0;
    int errors = 0;

    fifo_axi_burst_writer #(
        .BURST_LEN    (4),
        .BASE_ADDR    (32'h0000_0000),
        .REGION_BYTES (4096)
    ) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .fifo_empty    (fifo_empty),
        .fifo_data     (fifo_data),
        .fifo_r_en     (fifo_r_en),
        .flush         (flush),
        .awaddr        (awaddr),
        .awlen         (awlen),
        .awsize        (awsize),
        .awburst       (awburst),
        .awvalid       (awvalid),
        .awready       (awready),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wlast         (wlast),
        .wvalid        (wvalid),
        .wready        (wready),
        .bresp         (bresp),
        .bvalid        (bvalid),
        .bready        (bready),
        .busy          (busy),
        .err           (err),
        .bytes_written (bytes_written)
    );

    always #5 rclk = ~rclk;

    // FIFO read side: data appears the cycle after an accepted read.
    logic [7:0]  mem [0:8191];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rclk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr % 8192];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [31:0] exp_w [16];
    logic [31:0] exp_m [16];
    logic [3:0]  exp_s [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n, input logic [7:0] s);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 8192] = s + 8'(i);
            wr_ptr             = wr_ptr + 1;
        end
    endtask

    task automatic set_full(input logic [7:0] s);
        for (int j = 0; j < 4; j++) begin
            logic [7:0] b0;
            b0       = s + 8'(4 * j);
            exp_w[j] = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
            exp_m[j] = 32'hFFFF_FFFF;
            exp_s[j] = 4'hF;
        end
    endtask

    task automatic run_burst(input logic [31:0] a, input int nbeats, input logic [1:0] resp,
                             input int aw_stall, input bit tog, input logic [31:0] exp_bw);
        int t;
        t = 0;
        while (awvalid !== 1'b1 && t < 300) begin
            @(negedge rclk);
            t++;
        end
        check("aw_seen", awvalid, 1);
        check("awaddr", awaddr, a);
        check("awlen", awlen, 32'(nbeats - 1));
        check("awsize", awsize, 3'b010);
        check("awburst", awburst, 2'b01);
        check("w_before_aw", wvalid, 0);
        for (int i = 0; i < aw_stall; i++) begin
            @(negedge rclk);
            check("aw_hold_valid", awvalid, 1);
            check("aw_hold_addr", awaddr, a);
            check("aw_hold_len", awlen, 32'(nbeats - 1));
            check("w_early", wvalid, 0);
        end
        awready = 1'b1;
        @(negedge rclk);
        awready = 1'b0;
        check("aw_drop", awvalid, 0);
        for (int b = 0; b < nbeats; b++) begin
            check("wvalid", wvalid, 1);
            check("wdata", wdata & exp_m[b], exp_w[b]);
            check("wstrb", wstrb, exp_s[b]);
            check("wlast", wlast, (b == nbeats - 1) ? 1 : 0);
            if (tog) begin
                wready = 1'b0;
                @(negedge rclk);
                check("w_hold_valid", wvalid, 1);
                check("w_hold_data", wdata & exp_m[b], exp_w[b]);
                check("w_hold_last", wlast, (b == nbeats - 1) ? 1 : 0);
            end
            wready = 1'b1;
            @(negedge rclk);
            wready = 1'b0;
        end
        check("w_done", wvalid, 0);
        check("bready", bready, 1);
        bresp  = resp;
        bvalid = 1'b1;
        @(negedge rclk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        check("bready_drop", bready, 0);
        check("bytes_written", bytes_written, exp_bw);
    endtask

    initial begin
        logic [31:0] bw;
        int          t;
        rrst    = 1'b0;
        flush   = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;

        // Reset state
        @(negedge rclk);
        check("rst_fifo_r_en", fifo_r_en, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_bready", bready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_bytes", bytes_written, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", awlen, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 0);
        @(negedge rclk);
        rrst = 1'b1;

        // Full burst of 0x00..0x0F
        push(16, 8'h00);
        set_full(8'h00);
        run_burst(32'h0, 4, 2'b00, 0, 1'b0, 32'd16);

        // Six bytes then flush: two beats, last strobe 4'b0011
        push(6, 8'h00);
        repeat (12) @(negedge rclk);
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        exp_w[0] = 32'h0302_0100; exp_m[0] = 32'hFFFF_FFFF; exp_s[0] = 4'hF;
        exp_w[1] = 32'h0000_0504; exp_m[1] = 32'h0000_FFFF; exp_s[1] = 4'b0011;
        run_burst(32'h10, 2, 2'b00, 0, 1'b0, 32'd22);

        // Flush with nothing buffered issues nothing
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        repeat (8) @(negedge rclk);
        check("idle_flush_awvalid", awvalid, 0);
        check("idle_flush_busy", busy, 0);

        // awready held low 5 cycles, wready toggling
        push(16, 8'h10);
        set_full(8'h10);
        run_burst(32'h20, 4, 2'b00, 5, 1'b1, 32'd38);

        // SLVERR response sets sticky err, count still advances
        push(16, 8'h20);
        set_full(8'h20);
        run_burst(32'h30, 4, 2'b10, 0, 1'b0, 32'd54);
        check("err_set", err, 1);
        push(16, 8'h30);
        set_full(8'h30);
        run_burst(32'h40, 4, 2'b00, 0, 1'b0, 32'd70);
        check("err_sticky", err, 1);

        // Stream through the end of the region; last burst wraps to base
        bw = 32'd70;
        for (int k = 0; k < 252; k++) begin
            logic [7:0] s;
            s  = 8'(k * 16 + 8'h40);
            bw = bw + 32'd16;
            push(16, s);
            set_full(s);
            run_burst((32'h50 + 32'(k) * 32'd16) % 32'd4096, 4, 2'b00, 0, 1'b0, bw);
        end

        // Reset asserted while beat 2 is presented
        push(16, 8'hA0);
        set_full(8'hA0);
        t = 0;
        while (awvalid !== 1'b1 && t < 300) begin
            @(negedge rclk);
            t++;
        end
        check("mid_aw_seen", awvalid, 1);
        check("mid_awaddr", awaddr, 32'h10);
        awready = 1'b1;
        @(negedge rclk);
        awready = 1'b0;
        wready  = 1'b1;
        @(negedge rclk);
        @(negedge rclk);
        wready = 1'b0;
        check("mid_beat2_data", wdata, exp_w[2]);
        rrst = 1'b0;
        #1;
        check("mid_rst_wvalid", wvalid, 0);
        check("mid_rst_awvalid", awvalid, 0);
        check("mid_rst_bytes", bytes_written, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge rclk);
        rrst = 1'b1;
        push(16, 8'hB0);
        set_full(8'hB0);
        run_burst(32'h0, 4, 2'b00, 0, 1'b0, 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
